// File: rtl/hangman_pkg.sv
// hangman_pkg: shared letter width, word/miss limits and FSM encoding for the hangman datapath
package hangman_pkg;
  localparam int LETTER_W = 5;
  localparam int MAX_LEN = 16;
  localparam int MAX_MISS = 6;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;
endpackage

// File: rtl/hangman_timer.sv
// hangman_timer: per-round countdown in seconds, with a prescaler dividing clk down to 1 Hz
module hangman_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TIME_LIMIT = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       reload,
  input  logic       enable,
  output logic [6:0] seconds_left,
  output logic       timeout
);
  localparam int PW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic wrap;
  always_comb wrap = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge resetn)
    if (resetn || reload) begin
      pre <= '0;
      seconds_left <= 7'(TIME_LIMIT);
      timeout <= 1'b0;
    end else if (enable && !timeout) begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) begin
        seconds_left <= seconds_left - 7'd1;
        timeout <= seconds_left == 7'd1;
      end
    end
endmodule

// File: rtl/hangman_datapath.sv
// hangman_datapath: word storage, per-guess position scan, miss/win tracking and round countdown
module hangman_datapath #(
  parameter int MAX_LEN = hangman_pkg::MAX_LEN,
  parameter int MAX_MISS = hangman_pkg::MAX_MISS,
  parameter int TICK_DIV = 50_000_000,
  parameter int TIME_LIMIT = 60
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld,
  input  logic [4:0]         letter,
  input  logic               ldgraph,
  input  logic               timecount,
  input  logic               compare,
  input  logic [4:0]         guess,
  output logic [4:0]         address,
  output logic               match,
  output logic [4:0]         count,
  output logic               done,
  output logic [3:0]         misses,
  output logic               complete,
  output logic               filled,
  output logic               timeout,
  output logic [MAX_LEN-1:0] reveal,
  output logic [6:0]         seconds_left,
  output logic               busy
);
  import hangman_pkg::*;
  localparam int IW = $clog2(MAX_LEN);
  logic [1:0] state;
  logic [LETTER_W-1:0] word [MAX_LEN];
  logic [LETTER_W-1:0] guess_q;
  logic [4:0] idx, acc_cnt;
  logic acc_match, ld_q, cmp_q, blocked, ld_edge, cmp_edge, hit, fresh, last;
  logic [MAX_LEN-1:0] lmask;
  always_comb begin
    busy = state != IDLE;
    done = state == REPORT && !ldgraph;
    complete = misses == 4'(MAX_MISS);
    blocked = busy | complete | timeout;
    ld_edge = ld & ~ld_q & ~blocked & (address != 5'(MAX_LEN));
    cmp_edge = compare & ~cmp_q & ~blocked & ~ldgraph;
    hit = word[idx[IW-1:0]] == guess_q;
    fresh = hit & ~reveal[idx[IW-1:0]];
    last = idx == address - 5'd1;
    lmask = ~({MAX_LEN{1'b1}} << address);
    filled = (address != 5'd0) && (&(reveal | ~lmask));
  end
  always_ff @(posedge clk or posedge resetn)
    if (resetn) begin
      state <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) word[i] <= '0;
      address <= '0;
      reveal <= '0;
      misses <= '0;
      match <= 1'b0;
      count <= '0;
      guess_q <= '0;
      idx <= '0;
      acc_cnt <= '0;
      acc_match <= 1'b0;
      ld_q <= 1'b0;
      cmp_q <= 1'b0;
    end else begin
      ld_q <= ld;
      cmp_q <= compare;
      if (ld_edge) begin
        word[address[IW-1:0]] <= letter;
        address <= address + 5'd1;
      end
      if (ldgraph) begin
        state <= IDLE;
        reveal <= '0;
        misses <= '0;
        match <= 1'b0;
        count <= '0;
      end else if (state == IDLE && cmp_edge) begin
        guess_q <= guess;
        idx <= '0;
        acc_cnt <= '0;
        acc_match <= 1'b0;
        state <= (address == 5'd0) ? REPORT : SCAN;
        if (address == 5'd0) begin
          match <= 1'b0;
          count <= '0;
        end
      end else if (state == SCAN) begin
        if (hit) reveal[idx[IW-1:0]] <= 1'b1;
        acc_match <= acc_match | hit;
        acc_cnt <= acc_cnt + 5'(fresh);
        idx <= idx + 5'd1;
        if (last) begin
          state <= REPORT;
          match <= acc_match | hit;
          count <= acc_cnt + 5'(fresh);
        end
      end else if (state == REPORT) begin
        state <= IDLE;
        // an empty word never counts as a miss
        if (!match && address != 5'd0 && misses != 4'(MAX_MISS)) misses <= misses + 4'd1;
      end
    end
  hangman_timer #(.TICK_DIV(TICK_DIV), .TIME_LIMIT(TIME_LIMIT)) u_timer (
    .clk(clk),
    .resetn(resetn),
    .reload(ldgraph),
    .enable(timecount),
    .seconds_left(seconds_left),
    .timeout(timeout)
  );
endmodule
